// File: rtl/reg_file_mp_pkg.sv
// Shared types and default widths for the multi-port decode register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_file_mp_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_NUM_WR   = 2;
   localparam int DEF_PC_W     = 32;
   localparam int DEF_XADDR_W  = 32;

   typedef enum logic {
      PRIV_USER       = 1'b0,
      PRIV_SUPERVISOR = 1'b1
   } priv_mode_t;

   typedef enum logic [3:0] {
      XCPT_NONE           = 4'd0,
      XCPT_ILLEGAL_INSTR  = 4'd1,
      XCPT_PAGE_FAULT     = 4'd2,
      XCPT_MISALIGNED     = 4'd3,
      XCPT_PRIV_VIOLATION = 4'd4,
      XCPT_SYSCALL        = 4'd5
   } xcpt_type_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on alloc, cleared on write or flush.
// Latency: pending updates visible next cycle; busy lookup is combinational.
// Backpressure: none; alloc/write/flush are sampled every cycle.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   alloc_en_i/addr_i producer issue marks a destination pending
//   wr_en_i/addr_i    writeback strobes clear pending bits
//   flush_i           clears every pending bit (alloc still wins)
//   rd_addr_i         read addresses; rd_busy_o the matching busy bits
module reg_scoreboard
   import reg_file_mp_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter bit BYPASS   = 1'b1,
   parameter bit R0_ZERO  = 1'b0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           alloc_en_i,
   input  logic [ADDR_W-1:0]              alloc_addr_i,
   input  logic [NUM_WR-1:0]              wr_en_i,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
   input  logic                           flush_i,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
   output logic [NUM_RD-1:0]              rd_busy_o
);

   logic [NUM_REGS-1:0] pend_q, pend_d;

   // Priority per register: alloc > write > flush > hold.
   always_comb begin
      logic alloc_hit;
      logic wr_hit;
      pend_d = pend_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         alloc_hit = alloc_en_i && (alloc_addr_i == ADDR_W'(r));
         wr_hit    = 1'b0;
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p] == ADDR_W'(r))) begin
               wr_hit = 1'b1;
            end
         end
         if (alloc_hit) begin
            pend_d[r] = 1'b1;
         end else if (wr_hit || flush_i) begin
            pend_d[r] = 1'b0;
         end
      end
      // Register 0 can never become pending when it is hardwired.
      if (R0_ZERO) begin
         pend_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // With bypass, a same-cycle write already supplies the data, so the
   // reader is only busy if a new producer claims the register this cycle.
   always_comb begin
      logic wr_match;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy_o[i] = pend_q[rd_addr_i[i]];
         if (BYPASS) begin
            wr_match = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_en_i[p] && (wr_addr_i[p] == rd_addr_i[i])) begin
                  wr_match = 1'b1;
               end
            end
            if (wr_match) begin
               rd_busy_o[i] = alloc_en_i && (alloc_addr_i == rd_addr_i[i]);
            end
         end
         if (R0_ZERO && (rd_addr_i[i] == '0)) begin
            rd_busy_o[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with pending-write scoreboard and exception/privilege state.
// Latency: reads combinational (0 cycles; writes forwarded same cycle when BYPASS=1); all state updates next cycle.
// Backpressure: none; every strobe is a single-cycle qualifier sampled each cycle.
//
// Ports:
//   clock, reset                   clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy        NUM_RD operand read ports with busy bits
//   alloc_en/alloc_addr            mark a destination pending at issue
//   wr_en/wr_addr/wr_data          NUM_WR writeback ports (highest index wins)
//   flush                          clear all pending bits
//   iret_instr, xcpt_valid, xcpt_type, rmPC, rmAddr   exception control inputs
//   rm0_data/rm1_data/rm2_data     saved PC, fault address, cause
//   priv_mode, double_fault        current privilege, sticky double-fault flag
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int PC_W     = DEF_PC_W,
   parameter int XADDR_W  = DEF_XADDR_W,
   parameter bit BYPASS   = 1'b1,
   parameter bit R0_ZERO  = 1'b0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
   output logic [NUM_RD-1:0]              rd_busy,
   input  logic                           alloc_en,
   input  logic [ADDR_W-1:0]              alloc_addr,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   input  logic                           flush,
   input  logic                           iret_instr,
   input  logic                           xcpt_valid,
   input  xcpt_type_t                     xcpt_type,
   input  logic [PC_W-1:0]                rmPC,
   input  logic [XADDR_W-1:0]             rmAddr,
   output logic [DATA_W-1:0]              rm0_data,
   output logic [DATA_W-1:0]              rm1_data,
   output logic [DATA_W-1:0]              rm2_data,
   output priv_mode_t                     priv_mode,
   output logic                           double_fault
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic [DATA_W-1:0] rm0_q, rm0_d;
   logic [DATA_W-1:0] rm1_q, rm1_d;
   logic [DATA_W-1:0] rm2_q, rm2_d;
   priv_mode_t        priv_q, priv_d;
   logic              dfault_q, dfault_d;

   // ---------------- storage ----------------
   // Ports are walked in ascending order so the highest index wins a conflict.
   always_comb begin
      regs_d = regs_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && !(R0_ZERO && (wr_addr[p] == '0))) begin
            regs_d[wr_addr[p]] = wr_data[p];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data[i] = regs_q[rd_addr[i]];
         if (BYPASS) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_en[p] && (wr_addr[p] == rd_addr[i])) begin
                  rd_data[i] = wr_data[p];
               end
            end
         end
         if (R0_ZERO && (rd_addr[i] == '0)) begin
            rd_data[i] = '0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   // A taken exception discards all in-flight producers, same as flush.
   logic sb_flush;
   assign sb_flush = flush | xcpt_valid;

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .R0_ZERO  (R0_ZERO)
   ) u_scoreboard (
      .clk_i        (clock),
      .rst_i        (reset),
      .alloc_en_i   (alloc_en),
      .alloc_addr_i (alloc_addr),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .flush_i      (sb_flush),
      .rd_addr_i    (rd_addr),
      .rd_busy_o    (rd_busy)
   );

   // ---------------- exception / privilege ----------------
   // An exception outranks a same-cycle iret. Faulting while already in
   // Supervisor keeps the first fault's context and latches double_fault.
   always_comb begin
      rm0_d    = rm0_q;
      rm1_d    = rm1_q;
      rm2_d    = rm2_q;
      priv_d   = priv_q;
      dfault_d = dfault_q;
      if (xcpt_valid) begin
         if (priv_q == PRIV_USER) begin
            rm0_d  = DATA_W'(rmPC);
            rm1_d  = DATA_W'(rmAddr);
            rm2_d  = DATA_W'(xcpt_type);
            priv_d = PRIV_SUPERVISOR;
         end else begin
            dfault_d = 1'b1;
         end
      end else if (iret_instr && (priv_q == PRIV_SUPERVISOR)) begin
         priv_d = PRIV_USER;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rm0_q    <= '0;
         rm1_q    <= '0;
         rm2_q    <= '0;
         priv_q   <= PRIV_SUPERVISOR;
         dfault_q <= 1'b0;
      end else begin
         rm0_q    <= rm0_d;
         rm1_q    <= rm1_d;
         rm2_q    <= rm2_d;
         priv_q   <= priv_d;
         dfault_q <= dfault_d;
      end
   end

   assign rm0_data     = rm0_q;
   assign rm1_data     = rm1_q;
   assign rm2_data     = rm2_q;
   assign priv_mode    = priv_q;
   assign double_fault = dfault_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: instance a (BYPASS=1, R0_ZERO=0) and
// instance b (BYPASS=0, R0_ZERO=1) share one stimulus stream.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_reg_file_mp;
   import reg_file_mp_pkg::*;

   logic              clock = 1'b0;
   logic              reset;
   logic [1:0][4:0]   rd_addr;
   logic              alloc_en;
   logic [4:0]        alloc_addr;
   logic [1:0]        wr_en;
   logic [1:0][4:0]   wr_addr;
   logic [1:0][31:0]  wr_data;
   logic              flush;
   logic              iret_instr;
   logic              xcpt_valid;
   xcpt_type_t        xcpt_type;
   logic [31:0]       rmPC;
   logic [31:0]       rmAddr;

   logic [1:0][31:0]  rd_data_a, rd_data_b;
   logic [1:0]        rd_busy_a, rd_busy_b;
   logic [31:0]       rm0_a, rm1_a, rm2_a, rm0_b, rm1_b, rm2_b;
   priv_mode_t        priv_a, priv_b;
   logic              df_a, df_b;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   reg_file_mp #(.BYPASS(1'b1), .R0_ZERO(1'b0)) dut_a (
      .clock(clock), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flush(flush), .iret_instr(iret_instr), .xcpt_valid(xcpt_valid),
      .xcpt_type(xcpt_type), .rmPC(rmPC), .rmAddr(rmAddr),
      .rm0_data(rm0_a), .rm1_data(rm1_a), .rm2_data(rm2_a),
      .priv_mode(priv_a), .double_fault(df_a)
   );

   reg_file_mp #(.BYPASS(1'b0), .R0_ZERO(1'b1)) dut_b (
      .clock(clock), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flush(flush), .iret_instr(iret_instr), .xcpt_valid(xcpt_valid),
      .xcpt_type(xcpt_type), .rmPC(rmPC), .rmAddr(rmAddr),
      .rm0_data(rm0_b), .rm1_data(rm1_b), .rm2_data(rm2_b),
      .priv_mode(priv_b), .double_fault(df_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alloc_en   = 1'b0;
      alloc_addr = '0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      flush      = 1'b0;
      iret_instr = 1'b0;
      xcpt_valid = 1'b0;
      xcpt_type  = XCPT_NONE;
      rmPC       = '0;
      rmAddr     = '0;
   endtask

   initial begin
      reset   = 1'b1;
      rd_addr = '0;
      idle();
      tick();
      tick();
      reset = 1'b0;

      // ---- reset state ----
      for (int i = 0; i < 32; i++) begin
         rd_addr[0] = 5'(i);
         rd_addr[1] = 5'(31 - i);
         #1;
         chk("rst_data", {rd_data_a[0], rd_data_b[1]}, 64'h0);
         chk("rst_busy", {60'h0, rd_busy_a, rd_busy_b}, 64'h0);
      end
      chk("rst_priv_a", 64'(priv_a), 64'(PRIV_SUPERVISOR));
      chk("rst_priv_b", 64'(priv_b), 64'(PRIV_SUPERVISOR));
      chk("rst_df", {62'h0, df_a, df_b}, 64'h0);
      chk("rst_rm", {rm0_a, rm1_a | rm2_a}, 64'h0);
      tick();

      // ---- write conflict, highest port wins ----
      rd_addr[0] = 5'd5;
      wr_en      = 2'b11;
      wr_addr[0] = 5'd5; wr_data[0] = 32'hAA;
      wr_addr[1] = 5'd5; wr_data[1] = 32'hBB;
      #1;
      chk("conf_same_byp", 64'(rd_data_a[0]), 64'hBB);
      chk("conf_same_nobyp", 64'(rd_data_b[0]), 64'h0);
      tick();
      idle();
      #1;
      chk("conf_next_byp", 64'(rd_data_a[0]), 64'hBB);
      chk("conf_next_nobyp", 64'(rd_data_b[0]), 64'hBB);

      // ---- scoreboard ----
      rd_addr[1] = 5'd7;
      alloc_en = 1'b1; alloc_addr = 5'd7;
      tick();
      idle();
      #1;
      chk("alloc_busy", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h3);
      wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h77;
      #1;
      chk("wr_busy_same_a", 64'(rd_busy_a[1]), 64'h0);
      chk("wr_busy_same_b", 64'(rd_busy_b[1]), 64'h1);
      tick();
      idle();
      #1;
      chk("wr_busy_next", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h0);
      chk("wr_data_r7", {rd_data_a[1], rd_data_b[1]}, {32'h77, 32'h77});
      alloc_en = 1'b1; alloc_addr = 5'd7;
      wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 32'h78;
      #1;
      chk("allocwr_same_a", 64'(rd_busy_a[1]), 64'h1);
      chk("allocwr_same_b", 64'(rd_busy_b[1]), 64'h0);
      tick();
      idle();
      #1;
      chk("allocwr_next", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h3);
      chk("allocwr_data", {rd_data_a[1], rd_data_b[1]}, {32'h78, 32'h78});
      flush = 1'b1;
      #1;
      chk("flush_same", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h3);
      tick();
      idle();
      #1;
      chk("flush_next", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h0);
      alloc_en = 1'b1; alloc_addr = 5'd7; flush = 1'b1;
      tick();
      idle();
      #1;
      chk("alloc_beats_flush", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h3);
      flush = 1'b1;
      tick();
      idle();
      #1;
      chk("flush_again", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h0);

      // ---- privilege and exceptions ----
      rd_addr[1] = 5'd9;
      iret_instr = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
      tick();
      idle();
      #1;
      chk("iret_user", 64'(priv_a), 64'(PRIV_USER));
      chk("r9_busy", 64'(rd_busy_a[1]), 64'h1);
      xcpt_valid = 1'b1; rmPC = 32'h100; rmAddr = 32'h2000; xcpt_type = XCPT_PAGE_FAULT;
      tick();
      idle();
      #1;
      chk("x1_rm0", 64'(rm0_a), 64'h100);
      chk("x1_rm1", 64'(rm1_a), 64'h2000);
      chk("x1_rm2", 64'(rm2_a), 64'h2);
      chk("x1_priv", 64'(priv_a), 64'(PRIV_SUPERVISOR));
      chk("x1_df", 64'(df_a), 64'h0);
      chk("x1_flush_busy", {62'h0, rd_busy_a[1], rd_busy_b[1]}, 64'h0);
      xcpt_valid = 1'b1; rmPC = 32'h200; rmAddr = 32'h3000; xcpt_type = XCPT_ILLEGAL_INSTR;
      tick();
      idle();
      #1;
      chk("x2_rm0", 64'(rm0_a), 64'h100);
      chk("x2_rm1", 64'(rm1_a), 64'h2000);
      chk("x2_rm2", 64'(rm2_a), 64'h2);
      chk("x2_df", {62'h0, df_a, df_b}, 64'h3);
      iret_instr = 1'b1;
      tick();
      idle();
      #1;
      chk("iret2_user", 64'(priv_a), 64'(PRIV_USER));
      xcpt_valid = 1'b1; iret_instr = 1'b1; rmPC = 32'h300; rmAddr = 32'h40; xcpt_type = XCPT_SYSCALL;
      tick();
      idle();
      #1;
      chk("xiret_priv", 64'(priv_b), 64'(PRIV_SUPERVISOR));
      chk("xiret_rm0", 64'(rm0_a), 64'h300);
      chk("xiret_rm2", 64'(rm2_a), 64'h5);
      chk("xiret_df_sticky", 64'(df_a), 64'h1);
      iret_instr = 1'b1;
      tick();
      #1;
      chk("iret3_user", 64'(priv_a), 64'(PRIV_USER));
      tick();
      idle();
      #1;
      chk("iret_in_user", 64'(priv_a), 64'(PRIV_USER));
      chk("iret_in_user_rm0", 64'(rm0_a), 64'h300);

      // ---- register 0 ----
      rd_addr[0] = 5'd0;
      wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF;
      alloc_en = 1'b1; alloc_addr = 5'd0;
      #1;
      chk("r0_same_a", {31'h0, rd_busy_a[0], rd_data_a[0]}, {32'h1, 32'hFFFF});
      chk("r0_same_b", {31'h0, rd_busy_b[0], rd_data_b[0]}, 64'h0);
      tick();
      idle();
      #1;
      chk("r0_next_a", {31'h0, rd_busy_a[0], rd_data_a[0]}, {32'h1, 32'hFFFF});
      chk("r0_next_b", {31'h0, rd_busy_b[0], rd_data_b[0]}, 64'h0);

      // ---- reset overrides same-cycle strobes ----
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd5;
      reset = 1'b1;
      wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
      alloc_en = 1'b1; alloc_addr = 5'd3;
      xcpt_valid = 1'b1; rmPC = 32'h999;
      tick();
      reset = 1'b0;
      idle();
      #1;
      chk("mid_rst_data", {rd_data_a[0], rd_data_a[1]}, 64'h0);
      chk("mid_rst_busy", {60'h0, rd_busy_a, rd_busy_b}, 64'h0);
      chk("mid_rst_priv", 64'(priv_a), 64'(PRIV_SUPERVISOR));
      chk("mid_rst_df_rm0", {31'h0, df_a, rm0_a}, 64'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
